// File: rtl/n64_vbus_if.sv
// N64 digital video bus: nDSYNC-flagged 4-phase word stream plus field flag.
interface n64_vbus_if #(
   parameter int color_width_o = 7
);
   logic                     nDSYNC_o;
   logic [color_width_o-1:0] D_o;
   logic                     field_o;

   modport master (output nDSYNC_o, output D_o, output field_o);
   modport slave  (input  nDSYNC_o, input  D_o, input  field_o);
endinterface

// File: rtl/n64_vbus_gen.sv
// Synthetic N64 video bus source: colour-bar image with NTSC/PAL,
// progressive/interlaced sync timing on the 4-phase multiplexed bus.
module n64_vbus_gen #(
   parameter int color_width_o = 7,
   parameter int H_TOTAL       = 774,
   parameter int H_SYNC        = 57,
   parameter int H_CLAMP_START = 62,
   parameter int H_CLAMP_LEN   = 16,
   parameter int H_ACT_START   = 108,
   parameter int H_ACTIVE      = 640,
   parameter int V_SYNC        = 6,
   parameter int V_ACT_START   = 34,
   parameter int V_ACTIVE      = 480
) (
   input  logic       nCLK,
   input  logic       RST,
   input  logic       vmode_i,
   input  logic       n64_480i_i,
   n64_vbus_if.master vbus
);
   localparam int HB = $clog2(H_TOTAL) + 1;
   localparam int HW = (HB < 9) ? 9 : HB;
   localparam int VW = 10;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_MID_M1 = HW'(H_TOTAL / 2 - 1);
   localparam logic [HW-1:0] HS_END   = HW'(H_SYNC);
   localparam logic [HW-1:0] CL_BEG   = HW'(H_CLAMP_START);
   localparam logic [HW-1:0] CL_END   = HW'(H_CLAMP_START + H_CLAMP_LEN);
   localparam logic [HW-1:0] HA_BEG   = HW'(H_ACT_START);
   localparam logic [HW-1:0] HA_END   = HW'(H_ACT_START + H_ACTIVE);
   localparam logic [VW-1:0] VS_END   = VW'(V_SYNC);
   localparam logic [VW-1:0] VA_BEG   = VW'(V_ACT_START);
   localparam logic [VW-1:0] VA_END   = VW'(V_ACT_START + V_ACTIVE);

   typedef enum logic [1:0] {PH_SYNC, PH_R, PH_G, PH_B} phase_e;

   phase_e                   ph_q, ph_d;
   logic [HW-1:0]            h_cnt_q;
   logic [VW-1:0]            v_half_q;
   logic                     start_q;
   logic                     vmode_q;
   logic                     i480_q;
   logic                     field_q;
   logic                     nds_q;
   logic [color_width_o-1:0] d_q, d_d;

   logic [VW-1:0] fl_len;
   logic          half_step;
   logic          v_last;
   logic          n_hs, n_cl, n_vs;
   logic [3:0]    sync_word;
   logic          act;
   logic [HW-1:0] h_off;
   logic [2:0]    bar;

   always_comb begin
      unique case ({vmode_q, i480_q})
         2'b00:   fl_len = 10'd526;
         2'b01:   fl_len = 10'd525;
         2'b10:   fl_len = 10'd626;
         default: fl_len = 10'd625;
      endcase
      // progressive field that began mid-line runs one half-line longer to realign
      if (!i480_q && !field_q) fl_len = fl_len + 10'd1;

      half_step = (h_cnt_q == H_LAST) || (h_cnt_q == H_MID_M1);
      v_last    = (v_half_q == fl_len - 10'd1);

      n_hs      = !(h_cnt_q < HS_END);
      n_cl      = !((h_cnt_q >= CL_BEG) && (h_cnt_q < CL_END));
      n_vs      = !(v_half_q < VS_END);
      sync_word = {n_vs, n_cl, n_hs, ~(n_hs ^ n_vs)};

      act   = (h_cnt_q >= HA_BEG) && (h_cnt_q < HA_END) &&
              (v_half_q >= VA_BEG) && (v_half_q < VA_END);
      h_off = h_cnt_q - HA_BEG;
      bar   = h_off[8:6];

      unique case (ph_q)
         PH_SYNC: begin d_d = color_width_o'(sync_word);     ph_d = PH_R;    end
         PH_R:    begin d_d = {color_width_o{act & bar[2]}}; ph_d = PH_G;    end
         PH_G:    begin d_d = {color_width_o{act & bar[1]}}; ph_d = PH_B;    end
         default: begin d_d = {color_width_o{act & bar[0]}}; ph_d = PH_SYNC; end
      endcase
   end

   always_ff @(posedge nCLK or posedge RST) begin
      if (RST) begin
         ph_q     <= PH_SYNC;
         h_cnt_q  <= '0;
         v_half_q <= '0;
         start_q  <= 1'b1;
         vmode_q  <= 1'b0;
         i480_q   <= 1'b0;
         field_q  <= 1'b1;
         nds_q    <= 1'b1;
         d_q      <= '0;
      end else begin
         ph_q  <= ph_d;
         nds_q <= (ph_q != PH_SYNC);
         d_q   <= d_d;

         // mode and field flag change on the first sync slot of each field
         if (start_q && (ph_q == PH_SYNC)) begin
            vmode_q <= vmode_i;
            i480_q  <= n64_480i_i;
            field_q <= (h_cnt_q == '0);
            start_q <= 1'b0;
         end

         if (ph_q == PH_B) begin
            h_cnt_q <= (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
            if (half_step) begin
               if (v_last) begin
                  v_half_q <= '0;
                  start_q  <= 1'b1;
               end else begin
                  v_half_q <= v_half_q + 1'b1;
               end
            end
         end
      end
   end

   assign vbus.nDSYNC_o = nds_q;
   assign vbus.D_o      = d_q;
   assign vbus.field_o  = field_q;
endmodule

// File: tb/tb_n64_vbus_gen.sv
// Scoreboard bench: a positional video model predicts every pixel slot of two
// generator instances (full-width line timing, and a narrow line for field timing).
module tb_n64_vbus_gen;
   localparam int CW = 7;
   localparam int A_HT = 774, A_HS = 57, A_CLS = 62, A_CLL = 16, A_HAS = 108, A_HA = 640;
   localparam int A_VS = 6, A_VAS = 2, A_VA = 480;
   localparam int B_HT = 4, B_HS = 1, B_CLS = 1, B_CLL = 1, B_HAS = 2, B_HA = 2;
   localparam int B_VS = 6, B_VAS = 8, B_VA = 100;

   typedef struct packed {
      logic [CW-1:0] d0, d1, d2, d3;
      logic          f;
   } slot_t;

   logic nCLK  = 1'b0;
   logic rst_a = 1'b0, rst_b = 1'b0;
   logic vm_a  = 1'b0, il_a = 1'b0, vm_b = 1'b0, il_b = 1'b0;
   always #5 nCLK = ~nCLK;

   n64_vbus_if #(.color_width_o(CW)) bus_a ();
   n64_vbus_if #(.color_width_o(CW)) bus_b ();

   n64_vbus_gen #(.color_width_o(CW), .H_TOTAL(A_HT), .H_SYNC(A_HS), .H_CLAMP_START(A_CLS),
                  .H_CLAMP_LEN(A_CLL), .H_ACT_START(A_HAS), .H_ACTIVE(A_HA), .V_SYNC(A_VS),
                  .V_ACT_START(A_VAS), .V_ACTIVE(A_VA))
      dut_a (.nCLK(nCLK), .RST(rst_a), .vmode_i(vm_a), .n64_480i_i(il_a), .vbus(bus_a));

   n64_vbus_gen #(.color_width_o(CW), .H_TOTAL(B_HT), .H_SYNC(B_HS), .H_CLAMP_START(B_CLS),
                  .H_CLAMP_LEN(B_CLL), .H_ACT_START(B_HAS), .H_ACTIVE(B_HA), .V_SYNC(B_VS),
                  .V_ACT_START(B_VAS), .V_ACTIVE(B_VA))
      dut_b (.nCLK(nCLK), .RST(rst_b), .vmode_i(vm_b), .n64_480i_i(il_b), .vbus(bus_b));

   int n_cmp = 0, n_fail = 0;
   int n_slot [2] = '{0, 0};
   int al [2] = '{0, 0}, s [2] = '{0, 0}, nsl [2] = '{1, 1}, cyc [2] = '{0, 0}, fcnt [2] = '{0, 0};
   slot_t qa [$], qb [$];

   int            mph [2] = '{0, 0};
   logic          started [2] = '{1'b0, 1'b0};
   logic [CW-1:0] cd0 [2], cd1 [2], cd2 [2], cd3 [2];
   logic          cf [2], pok [2];

   function automatic slot_t model_slot(input int hs, cls, cll, has, ha, vs, vas, va, h, v,
                                        input logic odd);
      logic  nh, ncl, nv, act;
      int    bar;
      slot_t e;
      nh  = (h >= hs);
      ncl = !((h >= cls) && (h < cls + cll));
      nv  = (v >= vs);
      act = (h >= has) && (h < has + ha) && (v >= vas) && (v < vas + va);
      bar = act ? ((h - has) / 64) % 8 : 0;
      e.d0 = CW'({nv, ncl, nh, (nh == nv)});
      e.d1 = ((bar / 4) % 2 == 1) ? '1 : '0;
      e.d2 = ((bar / 2) % 2 == 1) ? '1 : '0;
      e.d3 = (bar % 2 == 1) ? '1 : '0;
      e.f  = odd;
      return e;
   endfunction

   // A field is FL half-lines long, i.e. FL*H/2 pixels counted from its start position.
   task automatic gen_step(input int i);
      logic  rst, pal, il;
      int    ht, fl, p, h, v;
      slot_t e;
      rst = (i == 0) ? rst_a : rst_b;
      pal = (i == 0) ? vm_a : vm_b;
      il  = (i == 0) ? il_a : il_b;
      ht  = (i == 0) ? A_HT : B_HT;
      if (rst) begin
         al[i] = 0; s[i] = 0; cyc[i] = 0;
         if (i == 0) qa.delete(); else qb.delete();
         return;
      end
      if (cyc[i] % 4 == 0) begin
         if (s[i] == 0) begin
            fl = (pal ? 626 : 526) - (il ? 1 : 0);
            if (!il && al[i] != 0) fl++;
            nsl[i] = fl * ht / 2;
         end
         p = al[i] + s[i];
         h = p % ht;
         v = p / (ht / 2) - al[i] / (ht / 2);
         if (i == 0) begin
            e = model_slot(A_HS, A_CLS, A_CLL, A_HAS, A_HA, A_VS, A_VAS, A_VA, h, v, al[i] == 0);
            qa.push_back(e);
         end else begin
            e = model_slot(B_HS, B_CLS, B_CLL, B_HAS, B_HA, B_VS, B_VAS, B_VA, h, v, al[i] == 0);
            qb.push_back(e);
         end
         s[i]++;
         if (s[i] == nsl[i]) begin
            al[i] = (al[i] + nsl[i]) % ht;
            s[i]  = 0;
            fcnt[i]++;
         end
      end
      cyc[i]++;
   endtask

   task automatic mon_step(input int i, input logic rst, input logic nds,
                           input logic [CW-1:0] d, input logic f);
      slot_t e, got;
      logic  have;
      if (rst) begin
         n_cmp++;
         if (nds !== 1'b1 || d !== '0 || f !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_out[%0d]: nDSYNC=%b D=%h field=%b, required 1 00 1", i, nds, d, f);
         end
         mph[i] = 0; started[i] = 1'b0;
         return;
      end
      if (mph[i] == 0) begin
         if (started[i]) begin
            n_cmp++;
            if (nds !== 1'b0) begin
               n_fail++;
               $display("FAIL dsync_phase0[%0d]: nDSYNC=%b, required 0", i, nds);
            end
         end
         if (nds === 1'b0) begin
            cd0[i] = d; cf[i] = f; pok[i] = 1'b1; mph[i] = 1;
         end
      end else begin
         if (nds !== 1'b1) pok[i] = 1'b0;
         case (mph[i])
            1:       cd1[i] = d;
            2:       cd2[i] = d;
            default: cd3[i] = d;
         endcase
         mph[i]++;
         if (mph[i] == 4) begin
            mph[i] = 0; started[i] = 1'b1; n_slot[i]++;
            got.d0 = cd0[i]; got.d1 = cd1[i]; got.d2 = cd2[i]; got.d3 = cd3[i]; got.f = cf[i];
            have = 1'b0;
            e    = '0;
            if (i == 0) begin
               if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
            end else begin
               if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
            end
            n_cmp++;
            if (!have) begin
               n_fail++;
               $display("FAIL slot_unexpected[%0d] #%0d: DUT produced a slot with none predicted", i, n_slot[i]);
            end else if (!pok[i] || got !== e) begin
               n_fail++;
               $display("FAIL slot[%0d] #%0d: got sync=%h R=%h G=%h B=%h field=%b dsync_ok=%b, required sync=%h R=%h G=%h B=%h field=%b",
                        i, n_slot[i], got.d0, got.d1, got.d2, got.d3, got.f, pok[i], e.d0, e.d1, e.d2, e.d3, e.f);
            end
         end
      end
   endtask

   always @(posedge nCLK) begin
      gen_step(0);
      gen_step(1);
   end

   always @(negedge nCLK) begin
      mon_step(0, rst_a, bus_a.nDSYNC_o, bus_a.D_o, bus_a.field_o);
      mon_step(1, rst_b, bus_b.nDSYNC_o, bus_b.D_o, bus_b.field_o);
   end

   task automatic wait_fields_b(input int k);
      int target, budget;
      target = fcnt[1] + k;
      budget = (k + 1) * 6000;
      while (fcnt[1] < target && budget > 0) begin
         @(posedge nCLK);
         budget--;
      end
   endtask

   // Mode inputs change well inside a field so the field-start sample is unambiguous.
   task automatic set_mid_b(input logic vm, input logic il, input logic want_odd);
      int   pct, budget;
      logic ok;
      pct    = int'($urandom_range(0, 20));
      budget = 12000;
      ok     = 1'b0;
      while (!ok && budget > 0) begin
         @(posedge nCLK);
         budget--;
         ok = (s[1] > nsl[1] * (25 + pct) / 100) && (s[1] < nsl[1] * 3 / 4) &&
              (!want_odd || al[1] == 0);
      end
      #1;
      vm_b = vm;
      il_b = il;
   endtask

   task automatic run_a();
      int   budget, hcur;
      logic ok;
      #1 rst_a = 1'b1;
      repeat (3) @(posedge nCLK);
      #1 rst_a = 1'b0;
      repeat (2 * A_HT * 4 + 37) @(posedge nCLK);
      budget = 8 * A_HT;
      ok     = 1'b0;
      while (!ok && budget > 0) begin
         @(posedge nCLK);
         #1;
         budget--;
         hcur = (al[0] + s[0] - 1) % A_HT;
         ok   = (cyc[0] % 4 == 2) && (hcur >= 364) && (hcur <= 490);
      end
      n_cmp++;
      if (bus_a.D_o !== 7'h7F) begin
         n_fail++;
         $display("FAIL pre_reset_red: D=%h, required 7f (bar 4/5 red phase)", bus_a.D_o);
      end
      rst_a = 1'b1;
      #1;
      n_cmp++;
      if (bus_a.nDSYNC_o !== 1'b1 || bus_a.D_o !== '0) begin
         n_fail++;
         $display("FAIL reset_async: nDSYNC=%b D=%h, required 1 00", bus_a.nDSYNC_o, bus_a.D_o);
      end
      repeat (3) @(posedge nCLK);
      #1 rst_a = 1'b0;
      repeat (A_HT * 4 + 50) @(posedge nCLK);
   endtask

   task automatic run_b();
      #1 rst_b = 1'b1;
      repeat (2) @(posedge nCLK);
      #1 rst_b = 1'b0;
      wait_fields_b(2);
      set_mid_b(1'b0, 1'b1, 1'b0);
      wait_fields_b(3);
      set_mid_b(1'b0, 1'b0, 1'b1);
      wait_fields_b(3);
      set_mid_b(1'b1, 1'b0, 1'b0);
      wait_fields_b(2);
      repeat (2) begin
         set_mid_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         wait_fields_b(1);
      end
   endtask

   initial begin
      fork
         run_a();
         run_b();
      join
      n_cmp++;
      if (n_slot[0] < 2500) begin
         n_fail++;
         $display("FAIL slots_seen_a: %0d slots, required at least 2500", n_slot[0]);
      end
      n_cmp++;
      if (n_slot[1] < 12000) begin
         n_fail++;
         $display("FAIL slots_seen_b: %0d slots, required at least 12000", n_slot[1]);
      end
      n_cmp++;
      if (qa.size() > 1 || qb.size() > 1) begin
         n_fail++;
         $display("FAIL slots_missing: %0d/%0d predicted slots never produced, required at most 1 each",
                  qa.size(), qb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
